// File: rtl/password_check_fsm_if.sv
// Handshake bundle for the password gate: golden-password programming, entry, and
// check result/status lines.
interface password_check_fsm_if #(
   parameter int PASS_W       = 32,
   parameter int MAX_ATTEMPTS = 3
);
   localparam int CNT_W = $clog2(MAX_ATTEMPTS + 1);

   logic              prog_valid;
   logic [PASS_W-1:0] prog_data;
   logic              prog_ready;
   logic              pass_valid;
   logic [PASS_W-1:0] pass_data;
   logic              pass_ready;
   logic              logout;
   logic              resp_valid;
   logic              resp_ok;
   logic              grant_access;
   logic              locked;
   logic [CNT_W-1:0]  fail_count;

   modport master (
      output prog_valid, prog_data, pass_valid, pass_data, logout,
      input  prog_ready, pass_ready, resp_valid, resp_ok, grant_access, locked, fail_count
   );

   modport slave (
      input  prog_valid, prog_data, pass_valid, pass_data, logout,
      output prog_ready, pass_ready, resp_valid, resp_ok, grant_access, locked, fail_count
   );
endinterface

// File: rtl/password_check_fsm.sv
// Password gate with a write-once golden value, data-independent check latency
// and a fixed-length lockout after repeated failures.
module password_check_fsm #(
   parameter int PASS_W         = 32,
   parameter int MAX_ATTEMPTS   = 3,
   parameter int LOCKOUT_CYCLES = 16
) (
   input logic                 clk,
   input logic                 resetn,
   password_check_fsm_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_ATTEMPTS + 1);
   localparam int LCK_W = $clog2(LOCKOUT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, CMP, RESP, GRANT, LOCKED} state_t;

   state_t            state;
   logic [PASS_W-1:0] golden;
   logic [PASS_W-1:0] diff;
   logic              golden_set;
   logic              mismatch;
   logic [CNT_W-1:0]  fail_count;
   logic [LCK_W-1:0]  lock_cnt;

   // Status lines decode only registered state, so they never depend on inputs.
   assign bus.prog_ready   = !golden_set && (state == IDLE);
   assign bus.pass_ready   = golden_set && (state == IDLE);
   assign bus.resp_valid   = (state == RESP);
   assign bus.resp_ok      = (state == RESP) && !mismatch;
   assign bus.grant_access = (state == GRANT);
   assign bus.locked       = (state == LOCKED);
   assign bus.fail_count   = fail_count;

   // The compare always walks IDLE->CMP->RESP with a full-width reduction, so the
   // answer arrives on the same cycle whatever bits differ.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         golden     <= '0;
         diff       <= '0;
         golden_set <= 1'b0;
         mismatch   <= 1'b0;
         fail_count <= '0;
         lock_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.prog_valid && !golden_set) begin
                  golden     <= bus.prog_data;
                  golden_set <= 1'b1;
               end
               if (bus.pass_valid && golden_set) begin
                  diff  <= bus.pass_data ^ golden;
                  state <= CMP;
               end
            end
            CMP: begin
               mismatch <= |diff;
               diff     <= '0;
               state    <= RESP;
            end
            RESP: begin
               if (!mismatch) begin
                  fail_count <= '0;
                  state      <= GRANT;
               end else if ((int'(fail_count) + 1) < MAX_ATTEMPTS) begin
                  fail_count <= fail_count + CNT_W'(1);
                  state      <= IDLE;
               end else begin
                  fail_count <= CNT_W'(MAX_ATTEMPTS);
                  lock_cnt   <= LCK_W'(LOCKOUT_CYCLES);
                  state      <= LOCKED;
               end
            end
            GRANT: begin
               if (bus.logout) begin
                  state <= IDLE;
               end
            end
            LOCKED: begin
               if (lock_cnt == LCK_W'(1)) begin
                  lock_cnt   <= '0;
                  fail_count <= '0;
                  state      <= IDLE;
               end else begin
                  lock_cnt <= lock_cnt - LCK_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_password_check_fsm.sv
// Scoreboard bench for password_check_fsm: directed scenarios followed by random
// entries, all checked against a simple behavioural model of the gate.
module tb_password_check_fsm;
   localparam int PASS_W         = 32;
   localparam int MAX_ATTEMPTS   = 3;
   localparam int LOCKOUT_CYCLES = 16;

   typedef struct {
      logic ok;
      int   cycle;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cycle = 0;
   int   compared = 0;
   int   mismatched = 0;
   exp_t sb[$];

   // Behavioural model of the gate: the stored password and the failure streak.
   logic [PASS_W-1:0] model_golden;
   logic              model_golden_set;
   int                model_fails;

   password_check_fsm_if #(.PASS_W(PASS_W), .MAX_ATTEMPTS(MAX_ATTEMPTS)) bus ();

   password_check_fsm #(
      .PASS_W(PASS_W),
      .MAX_ATTEMPTS(MAX_ATTEMPTS),
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
      end
   endtask

   // Monitor: every result pulse must match the oldest outstanding entry, on time.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn && bus.resp_valid) begin
            if (sb.size() == 0) begin
               check_output("unexpected_resp", 1, 0);
            end else begin
               e = sb.pop_front();
               check_output("resp_ok", bus.resp_ok, e.ok);
               check_output("resp_latency_cycle", cycle, e.cycle);
            end
         end
      end
   end

   task automatic do_reset();
      resetn = 1'b0;
      bus.prog_valid = 1'b0;
      bus.pass_valid = 1'b0;
      bus.logout     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_output("rst_prog_ready", bus.prog_ready, 1);
      check_output("rst_pass_ready", bus.pass_ready, 0);
      check_output("rst_resp_valid", bus.resp_valid, 0);
      check_output("rst_grant", bus.grant_access, 0);
      check_output("rst_locked", bus.locked, 0);
      check_output("rst_fail_count", bus.fail_count, 0);
      sb.delete();
      model_golden_set = 1'b0;
      model_golden     = '0;
      model_fails      = 0;
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic program_golden(input logic [PASS_W-1:0] v, input logic with_entry);
      logic expect_accept;
      @(negedge clk);
      expect_accept = !model_golden_set;
      check_output("prog_ready", bus.prog_ready, expect_accept);
      if (with_entry) check_output("pass_ready_while_unprogrammed", bus.pass_ready, 0);
      bus.prog_valid = 1'b1;
      bus.prog_data  = v;
      bus.pass_valid = with_entry;
      bus.pass_data  = v;
      @(negedge clk);
      bus.prog_valid = 1'b0;
      bus.pass_valid = 1'b0;
      if (expect_accept) begin
         model_golden     = v;
         model_golden_set = 1'b1;
      end
   endtask

   task automatic apply_stimulus(input logic [PASS_W-1:0] v, input logic abort_in_cmp);
      int   n;
      logic ok;
      n = 0;
      @(negedge clk);
      while (!bus.pass_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check_output("pass_ready_timeout", 0, 1);
         return;
      end
      ok = (v == model_golden);
      sb.push_back('{ok: ok, cycle: cycle + 2});
      bus.pass_valid = 1'b1;
      bus.pass_data  = v;
      @(negedge clk);
      bus.pass_valid = 1'b0;
      bus.pass_data  = $urandom;
      if (abort_in_cmp) begin
         do_reset();
         return;
      end
      @(negedge clk);
      @(negedge clk);
      if (ok) model_fails = 0;
      else    model_fails = model_fails + 1;
      check_output("grant_after_resp", bus.grant_access, ok);
      check_output("locked_after_resp", bus.locked, model_fails == MAX_ATTEMPTS);
      check_output("fail_count_after_resp", bus.fail_count, model_fails);
   endtask

   task automatic wait_lockout();
      int n;
      int ready_seen;
      n = 0;
      ready_seen = 0;
      while (bus.locked && n < 100) begin
         if (bus.pass_ready) ready_seen++;
         n++;
         @(negedge clk);
      end
      model_fails = 0;
      check_output("lockout_length", n, LOCKOUT_CYCLES);
      check_output("pass_ready_during_lock", ready_seen, 0);
      check_output("fail_count_after_lock", bus.fail_count, 0);
      check_output("pass_ready_after_lock", bus.pass_ready, 1);
   endtask

   task automatic do_logout(input int delay);
      repeat (delay) begin
         @(negedge clk);
         check_output("grant_held", bus.grant_access, 1);
      end
      bus.logout = 1'b1;
      @(negedge clk);
      bus.logout = 1'b0;
      check_output("grant_after_logout", bus.grant_access, 0);
      check_output("pass_ready_after_logout", bus.pass_ready, 1);
   endtask

   initial begin
      int bad;
      int r;
      logic [PASS_W-1:0] g;
      logic [PASS_W-1:0] v;
      bus.prog_valid = 1'b0;
      bus.prog_data  = '0;
      bus.pass_valid = 1'b0;
      bus.pass_data  = '0;
      bus.logout     = 1'b0;

      // Program with a simultaneous entry, then a correct entry and logout.
      do_reset();
      program_golden(32'hDEADBEEF, 1'b1);
      apply_stimulus(32'hDEADBEEF, 1'b0);
      do_logout(2);
      program_golden(32'h0, 1'b0);

      // LSB and MSB mismatches, then a success clearing the streak.
      apply_stimulus(32'hDEADBEEE, 1'b0);
      apply_stimulus(32'h5EADBEEF, 1'b0);
      apply_stimulus(32'hDEADBEEF, 1'b0);
      do_logout(0);

      // Three failures in a row lock the gate out.
      apply_stimulus(32'h00000000, 1'b0);
      apply_stimulus(32'hFFFFFFFF, 1'b0);
      apply_stimulus(32'h12345678, 1'b0);
      wait_lockout();

      // Nothing programmed: a held entry is never accepted.
      do_reset();
      bad = 0;
      bus.pass_valid = 1'b1;
      bus.pass_data  = 32'h0;
      repeat (10) begin
         @(negedge clk);
         if (bus.pass_ready) bad++;
      end
      bus.pass_valid = 1'b0;
      check_output("pass_ready_unprogrammed", bad, 0);

      // Reset in the middle of a check and in the middle of a lockout.
      program_golden(32'hCAFEF00D, 1'b0);
      apply_stimulus(32'hCAFEF00D, 1'b1);
      program_golden(32'hA5A5A5A5, 1'b0);
      repeat (MAX_ATTEMPTS) apply_stimulus(32'h5A5A5A5A, 1'b0);
      repeat (5) @(negedge clk);
      check_output("locked_before_reset", bus.locked, 1);
      do_reset();
      check_output("pass_ready_after_reset", bus.pass_ready, 0);

      // Random entries against a random golden value.
      g = $urandom;
      program_golden(g, 1'b0);
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 3);
         case (r)
            0:       v = g;
            1:       v = g ^ (32'h1 << $urandom_range(0, PASS_W - 1));
            2:       v = $urandom;
            default: v = g;
         endcase
         apply_stimulus(v, 1'b0);
         if (model_fails == MAX_ATTEMPTS) wait_lockout();
         else if (v == g) do_logout($urandom_range(0, 3));
      end

      repeat (4) @(negedge clk);
      check_output("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
